// File: rtl/serial_config_scheduler_if.sv
// Request, shifter and status signals shared by the
// configuration scheduler and whatever drives it.
interface serial_config_scheduler_if #(
  parameter int CNT_W = 16
);
  logic             host_req;
  logic             scrub_tick;
  logic             scrub_en;
  logic             alt_en;
  logic             comm_busy;
  logic             ser_busy;
  logic             ser_done;
  logic             ser_start;
  logic             cfg_sel;
  logic             sched_busy;
  logic             err_timeout;
  logic [CNT_W-1:0] prog_count;
  logic [CNT_W-1:0] scrub_count;
  logic [CNT_W-1:0] drop_count;

  modport master (
    output host_req, scrub_tick, scrub_en, alt_en,
    output comm_busy, ser_busy, ser_done,
    input  ser_start, cfg_sel, sched_busy, err_timeout,
    input  prog_count, scrub_count, drop_count
  );

  modport slave (
    input  host_req, scrub_tick, scrub_en, alt_en,
    input  comm_busy, ser_busy, ser_done,
    output ser_start, cfg_sel, sched_busy, err_timeout,
    output prog_count, scrub_count, drop_count
  );
endinterface

// File: rtl/serial_config_scheduler.sv
// Arbitrates host and scrub reprogramming runs of the TDC
// serial shifter, with I2C hold-off, watchdog and counters.
module serial_config_scheduler #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd8000000,
  parameter logic [15:0] GAP_CYCLES     = 16'd1000,
  parameter int          CNT_W          = 16
) (
  input logic                      clkin,
  input logic                      rst,
  serial_config_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, HOLD, START, RUN, GAP
  } state_t;

  state_t           state, state_nx;
  logic             host_pend, scrub_pend;
  logic             run_scrub, cfg_sel, err_to;
  logic [CNT_W-1:0] prog_cnt, scrub_cnt, drop_cnt;
  logic [23:0]      wd;
  logic [15:0]      gap;
  logic             scrub_req;
  logic             pick_host, pick_scrub;
  logic             done_ev, to_ev;
  logic             host_drop, scrub_drop;
  logic [CNT_W:0]   drop_sum;
  logic             unused;

  // ser_busy is informational only; completion is ser_done.
  assign unused = bus.ser_busy;

  assign scrub_req = bus.scrub_tick & bus.scrub_en;

  // A pulse landing on a flag that is being consumed this
  // cycle re-arms it rather than counting as a merge.
  assign host_drop  = bus.host_req & host_pend & ~pick_host;
  assign scrub_drop = scrub_req & scrub_pend
                    & ~(pick_host | pick_scrub);
  assign drop_sum   = {1'b0, drop_cnt}
                    + (CNT_W + 1)'(host_drop)
                    + (CNT_W + 1)'(scrub_drop);

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] c
  );
    return (c == '1) ? c : c + 1'b1;
  endfunction

  // Next-state and per-cycle event decode.
  always_comb begin
    state_nx   = state;
    pick_host  = 1'b0;
    pick_scrub = 1'b0;
    done_ev    = 1'b0;
    to_ev      = 1'b0;
    unique case (state)
      IDLE: begin
        if (host_pend | scrub_pend | bus.host_req | scrub_req)
          state_nx = HOLD;
      end
      HOLD: begin
        if (!bus.comm_busy) begin
          if (host_pend) begin
            pick_host = 1'b1;
            state_nx  = START;
          end else if (scrub_pend) begin
            pick_scrub = 1'b1;
            state_nx   = START;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      START: state_nx = RUN;
      RUN: begin
        if (bus.ser_done) begin
          done_ev  = 1'b1;
          state_nx = GAP;
        end else if (wd <= 24'd1) begin
          to_ev    = 1'b1;
          state_nx = GAP;
        end
      end
      GAP: begin
        if (gap == 16'd0) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Pending flags, timers, run source and status counters.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      host_pend  <= 1'b0;
      scrub_pend <= 1'b0;
      run_scrub  <= 1'b0;
      cfg_sel    <= 1'b0;
      err_to     <= 1'b0;
      prog_cnt   <= '0;
      scrub_cnt  <= '0;
      drop_cnt   <= '0;
      wd         <= '0;
      gap        <= '0;
    end else begin
      host_pend  <= bus.host_req | (host_pend & ~pick_host);
      scrub_pend <= scrub_req
                  | (scrub_pend & ~(pick_host | pick_scrub));
      if (pick_host | pick_scrub) run_scrub <= pick_scrub;

      if (state == START)
        wd <= TIMEOUT_CYCLES - 24'd1;
      else if (state == RUN && wd != 24'd0)
        wd <= wd - 24'd1;

      if (done_ev | to_ev)
        gap <= (GAP_CYCLES == 16'd0) ? 16'd0
                                     : GAP_CYCLES - 16'd1;
      else if (state == GAP && gap != 16'd0)
        gap <= gap - 16'd1;

      if (done_ev) begin
        prog_cnt <= sat_inc(prog_cnt);
        if (run_scrub) scrub_cnt <= sat_inc(scrub_cnt);
        if (run_scrub && bus.alt_en) cfg_sel <= ~cfg_sel;
      end
      if (to_ev) err_to <= 1'b1;

      if (drop_sum[CNT_W]) drop_cnt <= '1;
      else                 drop_cnt <= drop_sum[CNT_W-1:0];
    end
  end

  assign bus.ser_start   = (state == START);
  assign bus.sched_busy  = (state != IDLE);
  assign bus.cfg_sel     = cfg_sel;
  assign bus.err_timeout = err_to;
  assign bus.prog_count  = prog_cnt;
  assign bus.scrub_count = scrub_cnt;
  assign bus.drop_count  = drop_cnt;

endmodule

// File: tb/tb_serial_config_scheduler.sv
// Directed bench for serial_config_scheduler with a
// transaction-level expectation model checked every cycle.
module tb_serial_config_scheduler;

  localparam int          CNT_W = 16;
  localparam logic [23:0] TO    = 24'd50;
  localparam logic [15:0] GP    = 16'd20;

  logic clkin = 1'b0;
  logic rst   = 1'b1;

  int tests  = 0;
  int fails  = 0;
  int starts = 0;
  int s0;

  logic [CNT_W-1:0] exp_prog, exp_scrub, exp_drop;
  logic             exp_cfg, exp_err;

  serial_config_scheduler_if #(.CNT_W(CNT_W)) bus();

  serial_config_scheduler #(
    .TIMEOUT_CYCLES(TO),
    .GAP_CYCLES(GP),
    .CNT_W(CNT_W)
  ) dut (
    .clkin(clkin),
    .rst(rst),
    .bus(bus)
  );

  always #5 clkin = ~clkin;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clkin);
      #1;
    end
  endtask

  task automatic pulse(input logic h, input logic s,
                       input int drops);
    bus.host_req   = h;
    bus.scrub_tick = s;
    tick(1);
    bus.host_req   = 1'b0;
    bus.scrub_tick = 1'b0;
    exp_drop = exp_drop + CNT_W'(drops);
  endtask

  task automatic wait_start(input string name, input int base,
                            input int lat, input int budget);
    int n;
    n = base;
    while (!bus.ser_start && n < budget) begin
      tick(1);
      n++;
    end
    chk(name, 32'(n), 32'(lat));
  endtask

  task automatic finish_run(input int delay, input logic scrub);
    bus.ser_busy = 1'b1;
    tick(delay);
    bus.ser_done = 1'b1;
    tick(1);
    bus.ser_done = 1'b0;
    bus.ser_busy = 1'b0;
    exp_prog = exp_prog + 1'b1;
    if (scrub) exp_scrub = exp_scrub + 1'b1;
    if (scrub && bus.alt_en) exp_cfg = ~exp_cfg;
  endtask

  task automatic wait_idle(input string name, input int want);
    int n;
    n = 1;
    while (bus.sched_busy && n < 4 * int'(GP)) begin
      tick(1);
      n++;
    end
    chk(name, 32'(n), 32'(want));
  endtask

  task automatic clear_exp();
    exp_prog  = '0;
    exp_scrub = '0;
    exp_drop  = '0;
    exp_cfg   = 1'b0;
    exp_err   = 1'b0;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clkin);
      if (bus.ser_start) begin
        starts++;
        chk("start_busy", 32'(bus.sched_busy), 32'd1);
      end
      chk("prog", 32'(bus.prog_count), 32'(exp_prog));
      chk("scrub", 32'(bus.scrub_count), 32'(exp_scrub));
      chk("drop", 32'(bus.drop_count), 32'(exp_drop));
      chk("cfg", 32'(bus.cfg_sel), 32'(exp_cfg));
      chk("err", 32'(bus.err_timeout), 32'(exp_err));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not end");
    $fatal(1);
  end

  initial begin
    bus.host_req   = 1'b0;
    bus.scrub_tick = 1'b0;
    bus.scrub_en   = 1'b0;
    bus.alt_en     = 1'b0;
    bus.comm_busy  = 1'b0;
    bus.ser_busy   = 1'b0;
    bus.ser_done   = 1'b0;
    clear_exp();
    fork
      monitor();
    join_none

    tick(3);
    chk("rst_start", 32'(bus.ser_start), 32'd0);
    chk("rst_busy", 32'(bus.sched_busy), 32'd0);
    rst = 1'b0;
    tick(2);

    // stray done in IDLE is ignored
    bus.ser_done = 1'b1;
    tick(1);
    bus.ser_done = 1'b0;
    tick(2);
    chk("stray_busy", 32'(bus.sched_busy), 32'd0);

    // host request while idle
    pulse(1'b1, 1'b0, 0);
    wait_start("t1_lat", 1, 2, 10);
    finish_run(30, 1'b0);
    chk("t1_prog", 32'(bus.prog_count), 32'd1);
    chk("t1_scrub", 32'(bus.scrub_count), 32'd0);
    wait_idle("t1_gap", int'(GP) + 1);
    chk("t1_starts", 32'(starts), 32'd1);

    // host + scrub together: one host run only
    bus.scrub_en = 1'b1;
    pulse(1'b1, 1'b1, 0);
    wait_start("t2_lat", 1, 2, 10);
    finish_run(30, 1'b0);
    chk("t2_prog", 32'(bus.prog_count), 32'd2);
    chk("t2_scrub", 32'(bus.scrub_count), 32'd0);
    wait_idle("t2_gap", int'(GP) + 1);
    tick(30);
    chk("t2_starts", 32'(starts), 32'd2);
    chk("t2_idle", 32'(bus.sched_busy), 32'd0);

    // scrub held off by I2C traffic
    bus.comm_busy = 1'b1;
    pulse(1'b0, 1'b1, 0);
    tick(500);
    chk("t3_nostart", 32'(starts), 32'd2);
    chk("t3_hold", 32'(bus.sched_busy), 32'd1);
    bus.comm_busy = 1'b0;
    wait_start("t3_release", 0, 1, 10);
    bus.comm_busy = 1'b1;
    finish_run(30, 1'b1);
    chk("t3_scrub", 32'(bus.scrub_count), 32'd1);
    wait_idle("t3_gap", int'(GP) + 1);
    bus.comm_busy = 1'b0;

    // watchdog expiry
    pulse(1'b1, 1'b0, 0);
    wait_start("t4_lat", 1, 2, 10);
    for (int n = 1; n <= int'(TO); n++) begin
      tick(1);
      if (n == int'(TO) - 1)
        chk("t4_err_early", 32'(bus.err_timeout), 32'd0);
      if (n == int'(TO)) exp_err = 1'b1;
    end
    chk("t4_err", 32'(bus.err_timeout), 32'd1);
    chk("t4_prog", 32'(bus.prog_count), 32'd3);
    wait_idle("t4_gap", int'(GP) + 1);
    pulse(1'b1, 1'b0, 0);
    wait_start("t4_next", 1, 2, 10);
    finish_run(30, 1'b0);
    chk("t4_prog2", 32'(bus.prog_count), 32'd4);
    wait_idle("t4_gap2", int'(GP) + 1);

    // alternating register sets after a fresh reset
    rst = 1'b1;
    clear_exp();
    tick(2);
    rst = 1'b0;
    tick(2);
    bus.alt_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pulse(1'b0, 1'b1, 0);
      wait_start("t5_lat", 1, 2, 10);
      chk("t5_cfg_run", 32'(bus.cfg_sel), 32'(i % 2));
      finish_run(20, 1'b1);
      chk("t5_cfg", 32'(bus.cfg_sel), 32'((i + 1) % 2));
      wait_idle("t5_gap", int'(GP) + 1);
    end
    pulse(1'b1, 1'b0, 0);
    wait_start("t5_hlat", 1, 2, 10);
    finish_run(20, 1'b0);
    chk("t5_hcfg", 32'(bus.cfg_sel), 32'd1);
    chk("t5_scrub", 32'(bus.scrub_count), 32'd3);
    chk("t5_prog", 32'(bus.prog_count), 32'd4);
    wait_idle("t5_gap2", int'(GP) + 1);
    bus.alt_en = 1'b0;

    // merged requests during a run
    s0 = starts;
    pulse(1'b1, 1'b0, 0);
    wait_start("t6_lat", 1, 2, 10);
    tick(3);
    pulse(1'b1, 1'b0, 0);
    pulse(1'b1, 1'b0, 1);
    pulse(1'b1, 1'b0, 1);
    chk("t6_drop", 32'(bus.drop_count), 32'd2);
    finish_run(20, 1'b0);
    wait_idle("t6_gap", int'(GP) + 1);
    wait_start("t6_follow", 0, 2, 10);
    finish_run(20, 1'b0);
    wait_idle("t6_gap2", int'(GP) + 1);
    tick(10);
    chk("t6_starts", 32'(starts - s0), 32'd2);
    chk("t6_prog", 32'(bus.prog_count), 32'd6);

    // reset in the start cycle, then a late done
    pulse(1'b1, 1'b0, 0);
    wait_start("t7_lat", 1, 2, 10);
    #1;
    rst = 1'b1;
    clear_exp();
    #1;
    chk("t7_start", 32'(bus.ser_start), 32'd0);
    chk("t7_busy", 32'(bus.sched_busy), 32'd0);
    chk("t7_prog", 32'(bus.prog_count), 32'd0);
    chk("t7_drop", 32'(bus.drop_count), 32'd0);
    s0 = starts;
    tick(3);
    rst = 1'b0;
    tick(2);
    bus.ser_done = 1'b1;
    tick(1);
    bus.ser_done = 1'b0;
    tick(5);
    chk("t7_late_prog", 32'(bus.prog_count), 32'd0);
    chk("t7_late_busy", 32'(bus.sched_busy), 32'd0);
    chk("t7_starts", 32'(starts - s0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_config_scheduler.md
Name: serial_config_scheduler

Overview:
- Decides when the serial configuration shifter reprograms the TDC chip and which register set it loads.
- Two requesters share the shifter: a host request (start bit written over I2C) and a periodic scrub request (1 Hz tick), the scrub being for SEU refresh.
- Holds off while I2C traffic is active, watchdogs each programming run, and keeps status counters readable through the register bank.

Parameters:
- TIMEOUT_CYCLES, 24'd8000000: max cycles from ser_start until ser_done before the run is aborted.
- GAP_CYCLES, 16'd1000: minimum idle cycles after any run ends, before the next ser_start.
- CNT_W, 16: width of the status counters.

Ports:
- clkin  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- host_req  input  1  single-cycle pulse requesting a programming run.
- scrub_tick  input  1  single-cycle pulse from the 1 Hz source.
- scrub_en  input  1  level; enables scrub requests.
- alt_en  input  1  level; toggles cfg_sel after each scrub run.
- comm_busy  input  1  level; I2C active, so no new run may start.
- ser_busy  input  1  level from the shifter; high while it is shifting.
- ser_done  input  1  single-cycle pulse from the shifter at end of run.
- ser_start  output  1  single-cycle start pulse to the shifter.
- cfg_sel  output  1  selects register set 0 or 1; stable during a run.
- sched_busy  output  1  high in any state other than IDLE.
- err_timeout  output  1  sticky watchdog flag.
- prog_count  output  CNT_W  completed runs, both sources.
- scrub_count  output  CNT_W  completed scrub runs.
- drop_count  output  CNT_W  requests merged into an already-pending one.

Behaviour:
- Reset values: all outputs 0; state IDLE; pending flags cleared. Reset mid-run drops ser_start at once and discards the run, with no done accounting.
- Pending latches:
  - host_req sets host_pend.
  - scrub_tick sets scrub_pend, only if scrub_en=1.
  - A pulse arriving while its flag is already set increments drop_count (saturating).
  - Host and scrub pulses in the same cycle set both flags.
- States:
  - IDLE: if either flag is set, go to HOLD.
  - HOLD: wait until comm_busy=0. On the first such cycle, pick a source (host has priority) and clear the selected flag. If host was picked, also clear scrub_pend, because a host run refreshes all registers. Go to START.
  - START: ser_start=1 for exactly one cycle; load the watchdog; go to RUN. Start latency is one cycle after comm_busy falls, or 2 cycles from a request when comm_busy=0.
  - RUN: wait for ser_done. ser_busy is informational only; ser_done counts even if ser_busy never rose.
    - On ser_done: increment prog_count; also increment scrub_count for a scrub run. If the run was a scrub run and alt_en=1, toggle cfg_sel. Go to GAP.
    - On watchdog expiry (TIMEOUT_CYCLES cycles after START with no ser_done): set err_timeout, leave the counters unchanged, go to GAP.
  - GAP: count GAP_CYCLES, then go to IDLE.
- Ordering and edge rules:
  - ser_done and expiry in the same cycle: done wins, and err_timeout stays unchanged.
  - Requests arriving in HOLD, START, RUN or GAP only latch; they are served after GAP.
  - A stray ser_done outside RUN is ignored.
- cfg_sel changes only in the RUN-to-GAP transition.
- comm_busy rising during RUN or GAP has no effect on the current run.
- Counters saturate at all-ones and never wrap.
- err_timeout clears only on reset.
- Host requests are never suppressed by scrub_en.

Test Plan:
- Host request, idle: host_req pulse, comm_busy=0 → ser_start at request+2 cycles. Then ser_done 100 cycles later → prog_count=1, scrub_count=0, sched_busy low GAP_CYCLES+1 cycles after done.
- Priority and merge: host_req and scrub_tick in the same cycle → exactly one ser_start, host run, scrub_pend cleared. After ser_done → prog_count=1, scrub_count=0.
- Hold-off: scrub_tick with comm_busy=1 held for 500 cycles → no ser_start. ser_start one cycle after comm_busy falls.
- Timeout: ser_start issued, no ser_done (TIMEOUT_CYCLES set to 50 in bench) → err_timeout=1 at START+50, prog_count unchanged. A following host_req still runs normally.
- Alternate sets: alt_en=1, 3 scrub runs, then 1 host run → cfg_sel 0→1→0→1, host run leaves it at 1, scrub_count=3, prog_count=4.
- Drops and reset: 3 host_req pulses during RUN → drop_count=2 and exactly one follow-up run. rst asserted mid-RUN → all outputs 0 immediately, asynchronously; a later ser_done is ignored.
